label_ram_arb: RTL

Arbiter for the single-port labels RAM. It shares the RAM between two requesters: the video read path, which is the ORed address of all label vgaModules, and a write requester that updates label text. Video always has priority. Writes are queued in a small FIFO and drained only in windows where video does not need the RAM. The block sits between the label vgaModules / text writer and the `ram` instance, in the `px_clk` domain.

---
 rtl/label_ram_arb.sv | 138 +++++++++++++
 1 files changed

// File: rtl/label_ram_arb.sv
// Labels RAM arbiter: video reads always win; text writes wait in a small
// FIFO and drain only in windows where video does not need the RAM.
//
// state | meaning
// VIDEO | RAM owned by the video path; waiting for a window with queued writes
// ARM   | one guard cycle with no write before draining
// DRAIN | head of FIFO written each cycle while the window stays open
module label_ram_arb #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 4,
    parameter int BLANK_ONLY = 1
) (
    input  logic                       px_clk,
    input  logic                       rstn,
    input  logic                       vid_req,
    input  logic [ADDR_W-1:0]          vid_addr,
    input  logic                       vblank,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic                       ram_we,
    output logic [DATA_W-1:0]          ram_din,
    output logic [$clog2(DEPTH):0]     pending,
    output logic [7:0]                 wr_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        VIDEO = 2'd0,
        ARM   = 2'd1,
        DRAIN = 2'd2
    } arbState_t;

    arbState_t          state;
    arbState_t          nextState;
    logic [ADDR_W-1:0]  addrMem [DEPTH];
    logic [DATA_W-1:0]  dataMem [DEPTH];
    logic [PTR_W-1:0]   wrPtr;
    logic [PTR_W-1:0]   rdPtr;
    logic [CNT_W-1:0]   count;
    logic [7:0]         doneCnt;
    logic               win;
    logic               push;
    logic               pop;
    logic               writeNow;

    // The window is purely combinational so a video request preempts a write
    // in the very cycle it appears.
    assign win      = !vid_req && ((BLANK_ONLY == 0) || vblank);
    assign wr_ready = (count != FULL);
    assign push     = wr_valid && wr_ready;
    assign pop      = writeNow;

    assign ram_we   = writeNow;
    assign ram_addr = writeNow ? addrMem[rdPtr] : vid_addr;
    assign ram_din  = dataMem[rdPtr];
    assign pending  = count;
    assign wr_done  = doneCnt;

    // State register.
    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            state <= VIDEO;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and write-enable decode; occupancy is the pre-pop value.
    always_comb begin
        nextState = state;
        writeNow  = 1'b0;
        case (state)
            VIDEO: begin
                if (win && (count != '0)) begin
                    nextState = ARM;
                end
            end
            ARM: begin
                nextState = win ? DRAIN : VIDEO;
            end
            DRAIN: begin
                writeNow = win && (count != '0);
                if (!win || (count == '0)) begin
                    nextState = VIDEO;
                end
            end
            default: begin
                nextState = VIDEO;
            end
        endcase
    end

    // FIFO storage; no reset needed since entries are only read when valid.
    always_ff @(posedge px_clk) begin
        if (push) begin
            addrMem[wrPtr] <= wr_addr;
            dataMem[wrPtr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Committed-write counter, free-running modulo 256.
    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            doneCnt <= 8'd0;
        end else if (writeNow) begin
            doneCnt <= doneCnt + 8'd1;
        end
    end

endmodule
